// File: rtl/vedic_mul_pkg.sv
// Shared constants for the vedic multiplier scheduler and its arbiter.
package vedic_mul_pkg;

  localparam int MUL16_LAT = 5;
  localparam int OP_W      = 16;
  localparam int PROD_W    = 32;

  // Smallest w such that 2**w >= n.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first eligible index after rr_last, wrapping.
module rr_arbiter
  import vedic_mul_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] rr_last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_vld
);

  logic [IW-1:0] cand;

  // Scan rr_last+1 .. rr_last+N modulo N; the first hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(rr_last) + k) % N);
      if (!grant_vld && elig[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    if (grant_vld) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/vedic_mul_scheduler.sv
// Shares one pipelined 16x16 multiplier among N_REQ requesters. The multiplier
// has no handshake, so a valid/ID token travels alongside each operand pair
// and tags the product when it emerges MUL_LAT cycles later.
module vedic_mul_scheduler
  import vedic_mul_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int MUL_LAT = MUL16_LAT,
  parameter int ID_W    = clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [OP_W*N_REQ-1:0]   req_a,
  input  logic [OP_W*N_REQ-1:0]   req_b,
  output logic [OP_W-1:0]         mul_a,
  output logic [OP_W-1:0]         mul_b,
  input  logic [PROD_W-1:0]       mul_p,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [PROD_W-1:0]       rsp_data,
  output logic                    busy,
  output logic [15:0]             issue_count
);

  logic [N_REQ-1:0]             pending_q;
  logic [ID_W-1:0]              rr_last_q;
  logic [MUL_LAT:0]             tok_vld_q;
  logic [MUL_LAT:0][ID_W-1:0]   tok_id_q;
  logic [15:0]                  cnt_q;
  logic [OP_W-1:0]              mul_a_q, mul_b_q;
  logic [N_REQ-1:0]             rsp_valid_q;
  logic [PROD_W-1:0]            rsp_data_q;

  logic [N_REQ-1:0]             elig;
  logic [N_REQ-1:0]             grant;
  logic [ID_W-1:0]              gnt_idx;
  logic                         gnt_vld;
  logic                         tok_out_vld;
  logic [ID_W-1:0]              tok_out_id;
  logic [N_REQ-1:0]             rsp_clr;

  // A requester with an op in flight is not eligible until its response fires.
  assign elig = req_valid & ~pending_q;

  rr_arbiter #(.N(N_REQ), .IW(ID_W)) u_arb (
    .elig      (elig),
    .rr_last   (rr_last_q),
    .grant     (grant),
    .grant_idx (gnt_idx),
    .grant_vld (gnt_vld)
  );

  assign tok_out_vld = tok_vld_q[MUL_LAT];
  assign tok_out_id  = tok_id_q[MUL_LAT];

  // One-hot of the exiting token's owner; zero when no token exits.
  always_comb begin
    rsp_clr = '0;
    if (tok_out_vld) rsp_clr[tok_out_id] = 1'b1;
  end

  // Operand registers: only the granted slice is selected, so undriven
  // operands of other requesters never reach the multiplier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a_q <= '0;
      mul_b_q <= '0;
    end else if (gnt_vld) begin
      mul_a_q <= req_a[int'(gnt_idx)*OP_W +: OP_W];
      mul_b_q <= req_b[int'(gnt_idx)*OP_W +: OP_W];
    end
  end

  // Token pipe shifts every cycle; stage MUL_LAT lines up with mul_p.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tok_vld_q <= '0;
      tok_id_q  <= '0;
    end else begin
      tok_vld_q <= {tok_vld_q[MUL_LAT-1:0], gnt_vld};
      tok_id_q  <= {tok_id_q[MUL_LAT-1:0], gnt_idx};
    end
  end

  // Response register: capture the product when its token exits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_clr;
      if (tok_out_vld) rsp_data_q <= mul_p;
    end
  end

  // Bookkeeping: pending bits, round-robin pointer, issue counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      rr_last_q <= ID_W'(N_REQ - 1);
      cnt_q     <= '0;
    end else begin
      pending_q <= (pending_q & ~rsp_clr) | grant;
      if (gnt_vld) begin
        rr_last_q <= gnt_idx;
        cnt_q     <= cnt_q + 16'd1;
      end
    end
  end

  // Grant is combinational, so it is held off explicitly while reset is asserted.
  assign req_ready   = rst_n ? grant : '0;
  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign busy        = |pending_q;
  assign issue_count = cnt_q;

endmodule

// File: tb/tb_vedic_mul_scheduler.sv
// Bench for vedic_mul_scheduler: a 4-requester instance checked against a
// behavioural scheduling model, plus an 8-requester instance run saturated.
module tb_vedic_mul_scheduler;

  localparam int N  = 4;
  localparam int N8 = 8;
  localparam int L  = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]     req_valid, req_ready, rsp_valid;
  logic [16*N-1:0]  req_a, req_b;
  logic [15:0]      mul_a, mul_b, issue_count;
  logic [31:0]      mul_p, rsp_data;
  logic             busy;

  logic [N8-1:0]    req_valid8, req_ready8, rsp_valid8;
  logic [16*N8-1:0] req_a8, req_b8;
  logic [15:0]      mul_a8, mul_b8, issue_count8;
  logic [31:0]      mul_p8, rsp_data8;
  logic             busy8;

  vedic_mul_scheduler #(.N_REQ(N), .MUL_LAT(L)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy), .issue_count(issue_count)
  );

  vedic_mul_scheduler #(.N_REQ(N8), .MUL_LAT(L)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid8), .req_ready(req_ready8),
    .req_a(req_a8), .req_b(req_b8), .mul_a(mul_a8), .mul_b(mul_b8), .mul_p(mul_p8),
    .rsp_valid(rsp_valid8), .rsp_data(rsp_data8), .busy(busy8), .issue_count(issue_count8)
  );

  // Behavioural multipliers: product appears L register stages after operands.
  logic [31:0] pipe4 [L];
  logic [31:0] pipe8 [L];
  always @(posedge clk) begin
    pipe4[0] <= {16'b0, mul_a} * {16'b0, mul_b};
    pipe8[0] <= {16'b0, mul_a8} * {16'b0, mul_b8};
    for (int k = 1; k < L; k++) begin
      pipe4[k] <= pipe4[k-1];
      pipe8[k] <= pipe8[k-1];
    end
  end
  assign mul_p  = pipe4[L-1];
  assign mul_p8 = pipe8[L-1];

  typedef struct {
    int          due;
    int          id;
    logic [31:0] p;
  } exp_t;

  exp_t        q4[$];
  exp_t        q8[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [N-1:0] pend_m;
  int          rr_m;
  logic [15:0] cnt_m, cnt8_m;
  logic [31:0] last_data, last_data8;
  logic [15:0] last_a, last_b;
  int          nxt8;
  bit          track2 = 1'b0;
  int          prev_gnt2 = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q4.delete();
    q8.delete();
    pend_m     = '0;
    rr_m       = N - 1;
    cnt_m      = '0;
    cnt8_m     = '0;
    last_data  = '0;
    last_data8 = '0;
    last_a     = '0;
    last_b     = '0;
    nxt8       = 0;
    prev_gnt2  = -1;
  endtask

  task automatic reset_checks();
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_mul_a", 32'(mul_a), 32'h0);
    chk("rst_mul_b", 32'(mul_b), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_issue_count", 32'(issue_count), 32'h0);
    chk("rst_req_ready8", 32'(req_ready8), 32'h0);
    chk("rst_rsp_valid8", 32'(rsp_valid8), 32'h0);
  endtask

  // One clock cycle: compare both DUTs against the model mid-cycle, then
  // advance past the rising edge. Inputs must be set before calling.
  task automatic tick();
    logic [N-1:0]  elig, exp_rdy, exp_rsp;
    logic [N8-1:0] exp_rdy8, exp_rsp8;
    logic [31:0]   exp_data, exp_data8, prod;
    int            win;
    exp_t          e;
    @(negedge clk);
    exp_rsp  = '0;
    exp_data = last_data;
    if (q4.size() > 0 && q4[0].due == cyc) begin
      e = q4.pop_front();
      exp_rsp[e.id] = 1'b1;
      exp_data = e.p;
      pend_m[e.id] = 1'b0;
    end
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
    chk("rsp_data", rsp_data, exp_data);
    last_data = exp_data;
    chk("busy", 32'(busy), 32'(|pend_m));
    chk("issue_count", 32'(issue_count), 32'(cnt_m));
    chk("mul_a_hold", 32'(mul_a), 32'(last_a));
    chk("mul_b_hold", 32'(mul_b), 32'(last_b));
    elig = req_valid & ~pend_m;
    win = -1;
    for (int k = 1; k <= N; k++)
      if (win < 0 && elig[(rr_m + k) % N]) win = (rr_m + k) % N;
    exp_rdy = '0;
    if (win >= 0) exp_rdy[win] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (win >= 0) begin
      last_a = req_a[16*win +: 16];
      last_b = req_b[16*win +: 16];
      prod   = {16'b0, last_a} * {16'b0, last_b};
      q4.push_back('{due: cyc + L + 2, id: win, p: prod});
      pend_m[win] = 1'b1;
      rr_m  = win;
      cnt_m = cnt_m + 16'd1;
      if (win == 2 && track2) begin
        if (prev_gnt2 >= 0) chk("req2_regrant_gap", 32'(cyc - prev_gnt2), 32'(L + 2));
        prev_gnt2 = cyc;
      end
    end

    // Saturated 8-requester instance: strict rotation, one issue every cycle.
    exp_rsp8  = '0;
    exp_data8 = last_data8;
    if (q8.size() > 0 && q8[0].due == cyc) begin
      e = q8.pop_front();
      exp_rsp8[e.id] = 1'b1;
      exp_data8 = e.p;
    end
    chk("rsp_valid8", 32'(rsp_valid8), 32'(exp_rsp8));
    chk("rsp_data8", rsp_data8, exp_data8);
    last_data8 = exp_data8;
    chk("issue_count8", 32'(issue_count8), 32'(cnt8_m));
    exp_rdy8 = '0;
    exp_rdy8[nxt8] = 1'b1;
    chk("req_ready8", 32'(req_ready8), 32'(exp_rdy8));
    prod = {16'b0, req_a8[16*nxt8 +: 16]} * {16'b0, req_b8[16*nxt8 +: 16]};
    q8.push_back('{due: cyc + L + 2, id: nxt8, p: prod});
    nxt8   = (nxt8 + 1) % N8;
    cnt8_m = cnt8_m + 16'd1;

    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N8; i++) begin
      req_a8[16*i +: 16] = 16'($urandom);
      req_b8[16*i +: 16] = 16'($urandom);
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      req_a[16*i +: 16] = 16'($urandom);
      req_b[16*i +: 16] = 16'($urandom);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_valid8 = '1;
    req_a8     = '0;
    req_b8     = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset_checks();
    rst_n = 1'b1;

    // Single op on req0: response 7 cycles after the grant cycle.
    req_valid = 4'b0001;
    req_a[15:0] = 16'h00FF;
    req_b[15:0] = 16'h0102;
    tick();
    req_valid = '0;
    repeat (6) tick();
    chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("single_rsp_data", rsp_data, 32'h000100FE);
    repeat (2) tick();

    // Boundary operands.
    req_valid = 4'b0010;
    req_a[31:16] = 16'hFFFF;
    req_b[31:16] = 16'hFFFF;
    tick();
    req_valid = '0;
    repeat (6) tick();
    chk("max_rsp_valid", 32'(rsp_valid), 32'h2);
    chk("max_rsp_data", rsp_data, 32'hFFFE0001);
    req_valid = 4'b1000;
    req_a[63:48] = 16'h0000;
    req_b[63:48] = 16'hFFFF;
    tick();
    req_valid = '0;
    repeat (6) tick();
    chk("zero_rsp_valid", 32'(rsp_valid), 32'h8);
    chk("zero_rsp_data", rsp_data, 32'h0);
    repeat (2) tick();

    // All requesters continuously valid.
    req_valid = '1;
    for (int c = 0; c < 40; c++) begin
      rand_ops();
      tick();
    end

    // Reset with operations in flight; requesters still asserting valid.
    rst_n = 1'b0;
    #1;
    reset_checks();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
    repeat (12) begin
      rand_ops();
      tick();
    end

    // Random valid patterns.
    for (int c = 0; c < 150; c++) begin
      req_valid = N'($urandom);
      rand_ops();
      tick();
    end

    // req2 alone: re-granted in the same cycle its response appears.
    req_valid = '0;
    repeat (10) tick();
    track2 = 1'b1;
    req_valid = 4'b0100;
    for (int c = 0; c < 25; c++) begin
      rand_ops();
      tick();
    end
    track2 = 1'b0;
    req_valid = '0;
    repeat (10) tick();

    // Issue counter wrap from 16'hFFFF.
    force u_dut4.cnt_q = 16'hFFFF;
    #1;
    release u_dut4.cnt_q;
    cnt_m = 16'hFFFF;
    tick();
    req_valid = 4'b0001;
    rand_ops();
    tick();
    req_valid = '0;
    tick();
    chk("count_wrap", 32'(issue_count), 32'h0);
    repeat (9) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
